// File: rtl/rk4_lbe_axis_stall_detector.sv
// AXIS stall detector: per-channel blocked flags and first-block capture
// feeding the HLS deadlock monitor of the RK4_LBE core.
//
// Optional feature macro: AXIS_STALL_TS_EN (cycle timestamp of capture).
//
// Ports:
//   clock, reset      clock; synchronous active-high reset
//   enable            0 clears counters and flags (capture kept)
//   thresh            stall threshold in cycles, 0 disables detection
//   inst_idle         core idle, stalls not counted while high
//   tvalid, tready    per-channel AXIS handshake signals
//   clear             pulse, clears the first-event capture
//   axis_block_sigs   per-channel registered blocked flags
//   block_any         OR of the blocked flags, same register stage
//   first_valid       sticky, a block was captured
//   first_ch          lowest channel rising at the capture edge
//   first_ts          timestamp of the capture (0 without the macro)
module rk4_lbe_axis_stall_detector #(
  parameter int                NUM_CH   = 2,
  parameter int                CNT_W    = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK = NUM_CH'(2'b10),
  parameter int                TS_W     = 32,
  localparam int               CH_W     =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              inst_idle,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              block_any,
  output logic              first_valid,
  output logic [CH_W-1:0]   first_ch,
  output logic [TS_W-1:0]   first_ts
);

  logic              det_on;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] qual;
  logic [NUM_CH-1:0] rise;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] blk_q, blk_d;
  logic              any_q, any_d;
  logic              fv_q, fv_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [TS_W-1:0]   fts_q, fts_d;
  logic [TS_W-1:0]   ts_d;

`ifdef AXIS_STALL_TS_EN
  logic [TS_W-1:0]   ts_q;

  // Free-running stamp; the capture loads the post-edge value so that
  // first_ts equals the cycle in which the flag is first visible.
  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`else
  always_comb begin
    ts_d = '0;
  end
`endif

  always_comb begin
    det_on = enable & ~inst_idle & (thresh != '0);
  end

  // Output channels stall on valid without ready, input channels on
  // ready without valid; a handshake is never a stall.
  always_comb begin
    stall = '0;
    qual  = '0;
    blk_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i] = DIR_MASK[i] ? (tvalid[i] & ~tready[i])
                             : (tready[i] & ~tvalid[i]);
      qual[i]  = stall[i] & det_on;
      if (qual[i]) begin
        cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = '0;
      end
      // Compare against the live threshold every edge.
      blk_d[i] = qual[i] & (cnt_d[i] >= thresh);
    end
    any_d = |blk_d;
    rise  = blk_d & ~blk_q;
  end

  // A rise coinciding with clear re-arms and loads in the same edge.
  always_comb begin
    fv_d  = fv_q;
    fch_d = fch_q;
    fts_d = fts_q;
    if (clear) begin
      fv_d = 1'b0;
    end
    if ((|rise) && (!fv_q || clear)) begin
      fv_d  = 1'b1;
      fts_d = ts_d;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (rise[i]) begin
          fch_d = CH_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      blk_q <= '0;
      any_q <= 1'b0;
      fv_q  <= 1'b0;
      fch_q <= '0;
      fts_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      blk_q <= blk_d;
      any_q <= any_d;
      fv_q  <= fv_d;
      fch_q <= fch_d;
      fts_q <= fts_d;
    end
  end

  assign axis_block_sigs = blk_q;
  assign block_any       = any_q;
  assign first_valid     = fv_q;
  assign first_ch        = fch_q;
  assign first_ts        = fts_q;

endmodule

// File: tb/tb_rk4_lbe_axis_stall_detector.sv
// Scoreboard bench for rk4_lbe_axis_stall_detector (2 channels,
// 4-bit counters so saturation is reachable in a short run).
module tb_rk4_lbe_axis_stall_detector;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 32;

`ifdef AXIS_STALL_TS_EN
  localparam logic [31:0] TS_CAP = 32'd8;
`else
  localparam logic [31:0] TS_CAP = 32'd0;
`endif

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              enable    = 1'b0;
  logic [CNT_W-1:0]  thresh    = '0;
  logic              inst_idle = 1'b0;
  logic [NUM_CH-1:0] tvalid    = '0;
  logic [NUM_CH-1:0] tready    = '0;
  logic              clear     = 1'b0;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              block_any;
  logic              first_valid;
  logic [0:0]        first_ch;
  logic [TS_W-1:0]   first_ts;

  rk4_lbe_axis_stall_detector #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIR_MASK (2'b10),
    .TS_W     (TS_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .thresh          (thresh),
    .inst_idle       (inst_idle),
    .tvalid          (tvalid),
    .tready          (tready),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .block_any       (block_any),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .first_ts        (first_ts)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  blk;
    logic        fv;
    logic        fch;
    logic        ts_chk;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        ts_chk_g = 1'b0;
  logic [31:0] ts_exp_g = '0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input int c, input int lo,
                                  input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("blk", 32'(axis_block_sigs), 32'(e.blk));
      check_eq("any", 32'(block_any), 32'(|e.blk));
      check_eq("fv", 32'(first_valid), 32'(e.fv));
      if (e.fv) check_eq("fch", 32'(first_ch), 32'(e.fch));
      if (e.ts_chk) check_eq("ts", first_ts, e.ts);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in it.
  task automatic cyc(input logic [3:0] th, input logic [1:0] tv,
                     input logic [1:0] tr, input logic idl,
                     input logic en, input logic clr,
                     input logic rst, input logic [1:0] eb,
                     input logic efv, input logic efc);
    exp_t e;
    @(posedge clock);
    #1;
    thresh    = th;
    tvalid    = tv;
    tready    = tr;
    inst_idle = idl;
    enable    = en;
    clear     = clr;
    reset     = rst;
    e.blk     = eb;
    e.fv      = efv;
    e.fch     = efc;
    e.ts_chk  = ts_chk_g;
    e.ts      = ts_exp_g;
    sb.push_back(e);
  endtask

  initial begin
    enable = 1'b1;
    thresh = 4'd4;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_blk", 32'(axis_block_sigs), 0);
    check_eq("rst_any", 32'(block_any), 0);
    check_eq("rst_fv", 32'(first_valid), 0);
    check_eq("rst_fch", 32'(first_ch), 0);
    check_eq("rst_ts", first_ts, 0);
    reset = 1'b0;

    // ch1 output stall 0..9, thresh 4 -> flag 4..10
    for (int c = 0; c < 13; c++)
      cyc(4, (c <= 9) ? 2'b10 : 2'b00, 2'b00, 0, 1, 0, 0,
          {in_rng(c, 4, 10), 1'b0}, c >= 4, 1'b1);

    // clear alone drops first_valid
    cyc(4, 2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 1, 1);
    cyc(4, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0);

    // ch0 input: 3 stalls, handshake, 3 stalls -> no flag
    for (int c = 0; c < 9; c++)
      cyc(4, (c == 3) ? 2'b01 : 2'b00,
          (c <= 6) ? 2'b01 : 2'b00, 0, 1, 0, 0, 2'b00, 0, 0);

    // both channels from cycle 0, thresh 2 -> first_ch 0
    for (int c = 0; c < 6; c++)
      cyc(2, (c <= 3) ? 2'b10 : 2'b00, (c <= 3) ? 2'b01 : 2'b00,
          0, 1, 0, 0, in_rng(c, 2, 4) ? 2'b11 : 2'b00,
          c >= 2, 1'b0);

    // later ch1 rise without clear is ignored
    for (int c = 0; c < 5; c++)
      cyc(2, (c <= 2) ? 2'b10 : 2'b00, 2'b00, 0, 1, 0, 0,
          {in_rng(c, 2, 3), 1'b0}, 1, 0);

    // clear on the same edge as a ch1 rise -> rise wins
    for (int c = 0; c < 5; c++)
      cyc(2, (c <= 2) ? 2'b10 : 2'b00, 2'b00, 0, 1, c == 1, 0,
          {in_rng(c, 2, 3), 1'b0}, 1, c >= 2);

    // threshold lowered mid-stall below the count
    for (int c = 0; c < 9; c++)
      cyc((c <= 4) ? 4'd10 : 4'd3, (c <= 6) ? 2'b10 : 2'b00,
          2'b00, 0, 1, 0, 0, {in_rng(c, 6, 7), 1'b0}, 1, 1);

    // enable dropped for one cycle mid-stall
    for (int c = 0; c < 14; c++)
      cyc(4, (c <= 11) ? 2'b10 : 2'b00, 2'b00, 0, c != 6, 0, 0,
          {in_rng(c, 4, 6) || in_rng(c, 11, 12), 1'b0}, 1, 1);

    // idle, then thresh 0, then real threshold: count starts at 0
    for (int c = 0; c < 38; c++)
      cyc((c >= 20 && c <= 29) ? 4'd0 : 4'd4,
          (c <= 35) ? 2'b10 : 2'b00, 2'b00, c < 20, 1, 0, 0,
          {in_rng(c, 34, 36), 1'b0}, 1, 1);

    // saturation at 15 with thresh 15, then reset mid-stall
    for (int c = 0; c < 40; c++)
      cyc(15, 2'b10, 2'b00, 0, 1, 0, 0,
          {c >= 15, 1'b0}, 1, 1);
    cyc(15, 2'b10, 2'b00, 0, 1, 0, 1, 2'b10, 1, 1);
    ts_chk_g = 1'b1;
    ts_exp_g = '0;
    cyc(15, 2'b10, 2'b00, 0, 1, 0, 1, 2'b00, 0, 0);

    // timestamp: stall from cycle 5 after reset, thresh 3
    for (int k = 0; k < 12; k++) begin
      ts_exp_g = (k >= 8) ? TS_CAP : 32'd0;
      cyc(3, in_rng(k, 5, 9) ? 2'b10 : 2'b00, 2'b00, 0, 1, 0, 0,
          {in_rng(k, 8, 10), 1'b0}, k >= 8, 1);
    end

    @(negedge clock);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
